// File: rtl/mem_arbiter.sv
// Byte-wide single-port RAM controller shared by instruction fetch and load/store.
// Serialises 1/2/4-byte transfers, assembles reads little-endian, pulses done once.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              mem_req,
  input  logic              mem_wr,
  input  logic [1:0]        mem_len,
  input  logic              mem_signed,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_IF_RD, S_MEM_RD, S_MEM_WR, S_DONE} state_t;

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] r_base, w_base;
  logic [2:0]        r_n, w_n;
  logic              r_sgn, w_sgn;
  logic [31:0]       r_wdata, w_wdata;
  logic [2:0]        r_cnt, w_cnt;
  logic [31:0]       r_buf, w_buf;
  logic [ADDR_W-1:0] r_ram_a, w_ram_a;
  logic [7:0]        r_ram_dout, w_ram_dout;
  logic              r_ram_wr, w_ram_wr;
  logic              r_if_done, w_if_done;
  logic              r_mem_done, w_mem_done;
  logic [31:0]       r_if_data, w_if_data;
  logic [31:0]       r_mem_rdata, w_mem_rdata;

  logic [2:0]        w_len_n;
  logic [ADDR_W-1:0] w_nxt_a;
  logic [31:0]       w_merged;
  logic [31:0]       w_ext;
  logic [7:0]        w_wbyte;

  assign if_done   = r_if_done;
  assign if_data   = r_if_data;
  assign mem_done  = r_mem_done;
  assign mem_rdata = r_mem_rdata;
  assign ram_a     = r_ram_a;
  assign ram_dout  = r_ram_dout;
  assign ram_wr    = r_ram_wr;
  assign busy      = (r_state != S_IDLE);

  always_comb begin
    unique case (mem_len)
      2'd0:    w_len_n = 3'd1;
      2'd1:    w_len_n = 3'd2;
      default: w_len_n = 3'd4;
    endcase
  end

  assign w_nxt_a = r_base + ADDR_W'(r_cnt);

  // r_cnt = k at edge Ek, so the incoming byte lands in lane k-1
  always_comb begin
    w_merged = r_buf;
    unique case (r_cnt)
      3'd1:    w_merged[7:0]   = ram_din;
      3'd2:    w_merged[15:8]  = ram_din;
      3'd3:    w_merged[23:16] = ram_din;
      default: w_merged[31:24] = ram_din;
    endcase
  end

  always_comb begin
    unique case (r_n)
      3'd1:    w_ext = {{24{r_sgn & w_merged[7]}},  w_merged[7:0]};
      3'd2:    w_ext = {{16{r_sgn & w_merged[15]}}, w_merged[15:0]};
      default: w_ext = w_merged;
    endcase
  end

  always_comb begin
    unique case (r_cnt[1:0])
      2'd0:    w_wbyte = r_wdata[7:0];
      2'd1:    w_wbyte = r_wdata[15:8];
      2'd2:    w_wbyte = r_wdata[23:16];
      default: w_wbyte = r_wdata[31:24];
    endcase
  end

  always_comb begin
    w_state     = r_state;
    w_base      = r_base;
    w_n         = r_n;
    w_sgn       = r_sgn;
    w_wdata     = r_wdata;
    w_cnt       = r_cnt;
    w_buf       = r_buf;
    w_ram_a     = r_ram_a;
    w_ram_dout  = r_ram_dout;
    w_ram_wr    = 1'b0;
    w_if_done   = 1'b0;
    w_mem_done  = 1'b0;
    w_if_data   = r_if_data;
    w_mem_rdata = r_mem_rdata;
    unique case (r_state)
      S_IDLE: begin
        // memory stage has fixed priority over fetch
        if (mem_req) begin
          w_base  = mem_addr;
          w_n     = w_len_n;
          w_sgn   = mem_signed;
          w_wdata = mem_wdata;
          w_cnt   = 3'd1;
          w_buf   = '0;
          w_ram_a = mem_addr;
          if (mem_wr) begin
            w_state    = S_MEM_WR;
            w_ram_dout = mem_wdata[7:0];
            w_ram_wr   = 1'b1;
          end else begin
            w_state = S_MEM_RD;
          end
        end else if (if_req && !if_flush) begin
          w_state = S_IF_RD;
          w_base  = if_addr;
          w_n     = 3'd4;
          w_sgn   = 1'b0;
          w_cnt   = 3'd1;
          w_buf   = '0;
          w_ram_a = if_addr;
        end
      end
      S_IF_RD, S_MEM_RD: begin
        if (r_state == S_IF_RD && if_flush) begin
          w_state = S_IDLE;
          w_cnt   = 3'd0;
        end else begin
          w_buf = w_merged;
          if (r_cnt == r_n) begin
            w_state = S_DONE;
            w_cnt   = 3'd0;
            if (r_state == S_IF_RD) begin
              w_if_done = 1'b1;
              w_if_data = w_ext;
            end else begin
              w_mem_done  = 1'b1;
              w_mem_rdata = w_ext;
            end
          end else begin
            w_ram_a = w_nxt_a;
            w_cnt   = r_cnt + 3'd1;
          end
        end
      end
      S_MEM_WR: begin
        if (r_cnt == r_n) begin
          w_state    = S_DONE;
          w_cnt      = 3'd0;
          w_mem_done = 1'b1;
        end else begin
          w_ram_a    = w_nxt_a;
          w_ram_dout = w_wbyte;
          w_ram_wr   = 1'b1;
          w_cnt      = r_cnt + 3'd1;
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  // rdy low freezes every register, so a stalled sequence resumes exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_n         <= '0;
      r_sgn       <= 1'b0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_ram_a     <= '0;
      r_ram_dout  <= '0;
      r_ram_wr    <= 1'b0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
    end else if (rdy) begin
      r_state     <= w_state;
      r_base      <= w_base;
      r_n         <= w_n;
      r_sgn       <= w_sgn;
      r_wdata     <= w_wdata;
      r_cnt       <= w_cnt;
      r_buf       <= w_buf;
      r_ram_a     <= w_ram_a;
      r_ram_dout  <= w_ram_dout;
      r_ram_wr    <= w_ram_wr;
      r_if_done   <= w_if_done;
      r_mem_done  <= w_mem_done;
      r_if_data   <= w_if_data;
      r_mem_rdata <= w_mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of loads/stores plus hand sequences
// for priority, flush, rdy stall and asynchronous reset.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst, rdy;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_data;
  logic        mem_req, mem_wr, mem_signed, mem_done;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr, busy;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  logic [39:0] wlog[$];

  always #5 if (clk_en) clk = ~clk;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_len(mem_len), .mem_signed(mem_signed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .busy(busy)
  );

  function automatic logic [7:0] ram_at(input logic [31:0] a);
    case (a)
      32'h1000: return 8'h13;  32'h1001: return 8'h05;
      32'h1002: return 8'h00;  32'h1003: return 8'h00;
      32'h2000: return 8'h93;  32'h2001: return 8'h00;
      32'h2002: return 8'h10;  32'h2003: return 8'h00;
      32'h0020: return 8'h80;
      32'h0040: return 8'h80;  32'h0041: return 8'h7F;
      32'h0050: return 8'h34;  32'h0051: return 8'hA2;
      32'h0052: return 8'h34;  32'h0053: return 8'hA2;
      32'h0060: return 8'h78;  32'h0061: return 8'h56;
      32'h0062: return 8'h34;  32'h0063: return 8'h12;
      32'h0070: return 8'h01;  32'h0071: return 8'h02;
      32'h0072: return 8'h03;  32'h0073: return 8'h84;
      32'hFFFFFFFE: return 8'hAA;  32'hFFFFFFFF: return 8'hBB;
      32'h0000: return 8'hCC;  32'h0001: return 8'hDD;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  always_comb ram_din = ram_at(ram_a);

  always @(posedge clk) if (rst && rdy && ram_wr) wlog.push_back({ram_a, ram_dout});
  always @(negedge clk) if (rst && ram_wr && !busy) viol++;

  typedef struct {
    logic        wr;
    logic [1:0]  len;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] exp;   // load result, or store data whose low N bytes must reach the RAM
    int          lat;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_mem(input vec_t v);
    int n, w0, cyc;
    n  = (v.len == 2'd0) ? 1 : (v.len == 2'd1) ? 2 : 4;
    w0 = wlog.size();
    mem_req = 1'b1; mem_wr = v.wr; mem_len = v.len; mem_signed = v.sgn;
    mem_addr = v.addr; mem_wdata = v.exp;
    cyc = 0;
    do begin tick; cyc++; end while (!mem_done && cyc < 30);
    mem_req = 1'b0;
    chk("latency", 64'(cyc), 64'(v.lat));
    if (!v.wr) chk("rdata", 64'(mem_rdata), 64'(v.exp));
    else begin
      chk("wr_count", 64'(wlog.size() - w0), 64'(n));
      for (int i = 0; i < n; i++)
        if (w0 + i < wlog.size())
          chk("wr_byte", 64'(wlog[w0+i]), 64'({32'(v.addr + 32'(i)), v.exp[8*i +: 8]}));
    end
    tick;
    chk("done_pulse", {62'd0, mem_done, busy}, 64'd0);
  endtask

  initial begin
    int cyc;
    vt[0]  = '{1'b0, 2'd0, 1'b0, 32'h40,       32'h00000080, 2};
    vt[1]  = '{1'b0, 2'd0, 1'b1, 32'h41,       32'h0000007F, 2};
    vt[2]  = '{1'b0, 2'd0, 1'b1, 32'h40,       32'hFFFFFF80, 2};
    vt[3]  = '{1'b0, 2'd1, 1'b1, 32'h50,       32'hFFFFA234, 3};
    vt[4]  = '{1'b0, 2'd1, 1'b0, 32'h52,       32'h0000A234, 3};
    vt[5]  = '{1'b0, 2'd2, 1'b0, 32'h60,       32'h12345678, 5};
    vt[6]  = '{1'b0, 2'd3, 1'b1, 32'h70,       32'h84030201, 5};
    vt[7]  = '{1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'hDDCCBBAA, 5};
    vt[8]  = '{1'b1, 2'd2, 1'b0, 32'h100,      32'hCAFEF00D, 5};
    vt[9]  = '{1'b1, 2'd0, 1'b0, 32'h200,      32'h123456AB, 2};
    vt[10] = '{1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h00001234, 3};
    vt[11] = '{1'b0, 2'd1, 1'b1, 32'h80,       32'hFFFFDBDA, 3};

    rst = 1'b0; rdy = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_wr = 1'b0; mem_len = '0; mem_signed = 1'b0;
    mem_addr = '0; mem_wdata = '0;
    #12;
    chk("rst_ram", {23'd0, ram_a, ram_dout, ram_wr}, 64'd0);
    chk("rst_out", {mem_rdata, if_data}, 64'd0);
    chk("rst_flags", {61'd0, if_done, mem_done, busy}, 64'd0);
    rst = 1'b1;
    tick;

    // word fetch
    if_req = 1'b1; if_addr = 32'h1000;
    tick;
    chk("if_a0", {31'd0, busy, ram_a}, {31'd0, 1'b1, 32'h1000});
    for (int k = 1; k < 4; k++) begin
      tick;
      chk("if_ak", {30'd0, if_done, ram_wr, ram_a}, {30'd0, 2'b00, 32'h1000 + 32'(k)});
    end
    tick;
    chk("if_done", {31'd0, if_done, if_data}, {31'd0, 1'b1, 32'h00000513});
    if_req = 1'b0;
    tick;
    chk("if_done_clr", {63'd0, if_done}, 64'd0);

    // simultaneous requests: memory first, fetch after DONE
    if_req = 1'b1; if_addr = 32'h3000;
    mem_req = 1'b1; mem_wr = 1'b0; mem_len = 2'd0; mem_signed = 1'b1; mem_addr = 32'h20;
    tick;
    chk("pri_a", 64'(ram_a), 64'h20);
    tick;
    chk("pri_done", {30'd0, mem_done, if_done, mem_rdata}, {30'd0, 2'b10, 32'hFFFFFF80});
    mem_req = 1'b0;
    tick;
    chk("pri_gap", {62'd0, busy, mem_done}, 64'd0);
    tick;
    chk("pri_if_acc", {31'd0, busy, ram_a}, {31'd0, 1'b1, 32'h3000});
    repeat (3) tick;
    tick;
    chk("pri_if_done", {31'd0, if_done, if_data}, {31'd0, 1'b1, 32'h59585B5A});
    if_req = 1'b0;
    tick;

    // half store
    mem_req = 1'b1; mem_wr = 1'b1; mem_len = 2'd1; mem_addr = 32'h30004; mem_wdata = 32'h0000BEEF;
    tick;
    chk("st_b0", {23'd0, ram_wr, ram_a, ram_dout}, {23'd0, 1'b1, 32'h30004, 8'hEF});
    tick;
    chk("st_b1", {22'd0, mem_done, ram_wr, ram_a, ram_dout}, {22'd0, 2'b01, 32'h30005, 8'hBE});
    tick;
    chk("st_done", {62'd0, mem_done, ram_wr}, {62'd0, 2'b10});
    mem_req = 1'b0;
    tick;
    chk("st_after", {62'd0, mem_done, ram_wr}, 64'd0);

    // flush during the third cycle of a fetch
    if_req = 1'b1; if_addr = 32'h1000;
    tick;
    tick;
    if_flush = 1'b1;
    tick;
    chk("fl_abort", {30'd0, busy, if_done, ram_a}, {30'd0, 2'b00, 32'h1001});
    chk("fl_data", 64'(if_data), 64'h59585B5A);
    if_flush = 1'b0; if_addr = 32'h2000;
    tick;
    chk("fl_new_acc", {31'd0, busy, ram_a}, {31'd0, 1'b1, 32'h2000});
    repeat (3) begin
      tick;
      chk("fl_no_done", {63'd0, if_done}, 64'd0);
    end
    tick;
    chk("fl_if_done", {31'd0, if_done, if_data}, {31'd0, 1'b1, 32'h00100093});
    if_req = 1'b0;
    tick;

    // rdy stall in the middle of a word load
    mem_req = 1'b1; mem_wr = 1'b0; mem_len = 2'd2; mem_signed = 1'b0; mem_addr = 32'h60;
    tick;
    tick;
    chk("rdy_pre", 64'(ram_a), 64'h61);
    rdy = 1'b0;
    tick;
    tick;
    chk("rdy_frozen", {30'd0, busy, mem_done, ram_a}, {30'd0, 2'b10, 32'h61});
    rdy = 1'b1;
    cyc = 4;
    do begin tick; cyc++; end while (!mem_done && cyc < 30);
    mem_req = 1'b0;
    chk("rdy_lat", 64'(cyc), 64'd7);
    chk("rdy_data", 64'(mem_rdata), 64'h12345678);
    tick;

    for (int i = 0; i < 12; i++) do_mem(vt[i]);

    // asynchronous reset mid-store with the clock stopped
    mem_req = 1'b1; mem_wr = 1'b1; mem_len = 2'd2; mem_addr = 32'h400; mem_wdata = 32'h11223344;
    tick;
    tick;
    chk("ar_pre", {62'd0, ram_wr, busy}, {62'd0, 2'b11});
    clk_en = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("ar_clear", {29'd0, ram_wr, busy, mem_done, ram_a}, 64'd0);
    mem_req = 1'b0;
    #2 rst = 1'b1;
    #1 clk_en = 1'b1;
    do_mem(vt[1]);

    chk("wr_outside", 64'(viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
